// File: rtl/id_ex_stage.sv
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register with load-use hazard detection and
//            saturating bubble counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage #(
  parameter int DATA_WIDTH   = 32,
  parameter int REG_ADDR     = 5,
  parameter int CONTROL_SIZE = 18,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_enable,
  input  logic                    i_flush,
  input  logic [CONTROL_SIZE-1:0] i_control,
  input  logic [DATA_WIDTH-1:0]   i_rs_data,
  input  logic [DATA_WIDTH-1:0]   i_rt_data,
  input  logic [DATA_WIDTH-1:0]   i_imm,
  input  logic [4:0]              i_shamt,
  input  logic [REG_ADDR-1:0]     i_rs,
  input  logic [REG_ADDR-1:0]     i_rt,
  input  logic [REG_ADDR-1:0]     i_rd,
  input  logic [DATA_WIDTH-1:0]   i_pc_plus4,
  output logic [CONTROL_SIZE-1:0] o_control,
  output logic [DATA_WIDTH-1:0]   o_rs_data,
  output logic [DATA_WIDTH-1:0]   o_rt_data,
  output logic [DATA_WIDTH-1:0]   o_imm,
  output logic [4:0]              o_shamt,
  output logic [REG_ADDR-1:0]     o_rs,
  output logic [REG_ADDR-1:0]     o_rt,
  output logic [REG_ADDR-1:0]     o_rd,
  output logic [DATA_WIDTH-1:0]   o_pc_plus4,
  output logic                    o_stall,
  output logic [CNT_WIDTH-1:0]    o_bubble_count
);

  localparam int MEM_READ_BIT = 3;

  logic [CONTROL_SIZE-1:0] control_q,    control_d;
  logic [DATA_WIDTH-1:0]   rs_data_q,    rs_data_d;
  logic [DATA_WIDTH-1:0]   rt_data_q,    rt_data_d;
  logic [DATA_WIDTH-1:0]   imm_q,        imm_d;
  logic [4:0]              shamt_q,      shamt_d;
  logic [REG_ADDR-1:0]     rs_q,         rs_d;
  logic [REG_ADDR-1:0]     rt_q,         rt_d;
  logic [REG_ADDR-1:0]     rd_q,         rd_d;
  logic [DATA_WIDTH-1:0]   pc_plus4_q,   pc_plus4_d;
  logic [CNT_WIDTH-1:0]    bubble_cnt_q, bubble_cnt_d;

  logic w_stall;
  logic w_bubble;
  logic w_cnt_full;

  // Both rs and rt are compared whatever the instruction format; false stalls are harmless.
  assign w_stall    = control_q[MEM_READ_BIT] && (rt_q != '0) &&
                      ((rt_q == i_rs) || (rt_q == i_rt));
  assign w_bubble   = i_flush || w_stall;
  assign w_cnt_full = (bubble_cnt_q == {CNT_WIDTH{1'b1}});

  always_comb begin
    control_d    = control_q;
    rs_data_d    = rs_data_q;
    rt_data_d    = rt_data_q;
    imm_d        = imm_q;
    shamt_d      = shamt_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    rd_d         = rd_q;
    pc_plus4_d   = pc_plus4_q;
    bubble_cnt_d = bubble_cnt_q;
    if (i_enable) begin
      control_d  = w_bubble ? '0 : i_control;
      rs_data_d  = i_rs_data;
      rt_data_d  = i_rt_data;
      imm_d      = i_imm;
      shamt_d    = i_shamt;
      rs_d       = i_rs;
      rt_d       = i_rt;
      rd_d       = i_rd;
      pc_plus4_d = i_pc_plus4;
      if (w_bubble && !w_cnt_full) begin
        bubble_cnt_d = bubble_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      control_q    <= '0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      shamt_q      <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      pc_plus4_q   <= '0;
      bubble_cnt_q <= '0;
    end else begin
      control_q    <= control_d;
      rs_data_q    <= rs_data_d;
      rt_data_q    <= rt_data_d;
      imm_q        <= imm_d;
      shamt_q      <= shamt_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      rd_q         <= rd_d;
      pc_plus4_q   <= pc_plus4_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign o_control      = control_q;
  assign o_rs_data      = rs_data_q;
  assign o_rt_data      = rt_data_q;
  assign o_imm          = imm_q;
  assign o_shamt        = shamt_q;
  assign o_rs           = rs_q;
  assign o_rt           = rt_q;
  assign o_rd           = rd_q;
  assign o_pc_plus4     = pc_plus4_q;
  assign o_stall        = w_stall;
  assign o_bubble_count = bubble_cnt_q;

endmodule

`default_nettype wire
